// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage slice.
// Holds the default datapath, specifier and counter widths plus the
// 4-bit ALU opcode encoding carried through ID/EX.
package id_ex_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_LUI  = 4'hA,
    ALU_PASS = 4'hF
  } alu_op_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded instruction from ID, register-file writeback port,
// pipeline control (hold/flush), and the registered EX-side view.
// master: decode/control side; slave: the id_ex_stage itself.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  // decode side
  logic                id_valid;
  logic [REG_AW-1:0]   id_read_reg1, id_read_reg2, id_write_reg;
  logic [DATA_W-1:0]   id_read_data1, id_read_data2, id_imm;
  logic                id_reg_write, id_mem_read, id_mem_write;
  logic [ALU_OP_W-1:0] id_alu_op;
  // writeback port into the register file this cycle
  logic [REG_AW-1:0]   wb_write_reg;
  logic                wb_reg_write;
  logic [DATA_W-1:0]   wb_write_data;
  // pipeline control
  logic                ex_hold, flush;
  // EX side (registered) and hazard feedback
  logic                ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic [REG_AW-1:0]   ex_read_reg1, ex_read_reg2, ex_write_reg;
  logic [DATA_W-1:0]   ex_data1, ex_data2, ex_imm;
  logic                stall_if_id;
  logic [CNT_W-1:0]    stall_count, flush_count;

  modport master (
    output id_valid, id_read_reg1, id_read_reg2, id_write_reg, id_read_data1,
           id_read_data2, id_imm, id_reg_write, id_mem_read, id_mem_write,
           id_alu_op, wb_write_reg, wb_reg_write, wb_write_data, ex_hold, flush,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op,
           ex_read_reg1, ex_read_reg2, ex_write_reg, ex_data1, ex_data2, ex_imm,
           stall_if_id, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_read_reg1, id_read_reg2, id_write_reg, id_read_data1,
           id_read_data2, id_imm, id_reg_write, id_mem_read, id_mem_write,
           id_alu_op, wb_write_reg, wb_reg_write, wb_write_data, ex_hold, flush,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op,
           ex_read_reg1, ex_read_reg2, ex_write_reg, ex_data1, ex_data2, ex_imm,
           stall_if_id, stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector (combinational).
// Flags when the load sitting in EX writes a register that the valid
// instruction in ID reads. x0 never hazards.
// Ports: id_valid, id_read_reg1/2 (ID sources); ex_valid, ex_mem_read,
// ex_write_reg (EX load); hazard (out).
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_read_reg1,
  input  logic [REG_AW-1:0] id_read_reg2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_write_reg,
  output logic              hazard
);
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_read_reg1) || (ex_write_reg == id_read_reg2));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, writeback
// bypass of the same-edge register-file write, and saturating
// stall/flush event counters.
// Ports: clk, rst_n (async, active-low); bus (id_ex_stage_if.slave)
// carrying decode inputs, writeback port, ex_hold/flush, registered ex_*
// outputs, combinational stall_if_id and the two counters.
// Edge priority: ex_hold > flush > load-use bubble > normal capture.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              hazard, byp1, byp2, take;
  logic [DATA_W-1:0] data1, data2;

  load_use_detect #(.REG_AW(REG_AW)) u_luse (
    .id_valid     (bus.id_valid),
    .id_read_reg1 (bus.id_read_reg1),
    .id_read_reg2 (bus.id_read_reg2),
    .ex_valid     (bus.ex_valid),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_write_reg (bus.ex_write_reg),
    .hazard       (hazard)
  );

  // The register file writes on the same edge we sample, so its read
  // data is stale for the register being written back.
  assign byp1  = bus.wb_reg_write && (bus.wb_write_reg != '0) &&
                 (bus.wb_write_reg == bus.id_read_reg1);
  assign byp2  = bus.wb_reg_write && (bus.wb_write_reg != '0) &&
                 (bus.wb_write_reg == bus.id_read_reg2);
  assign data1 = byp1 ? bus.wb_write_data : bus.id_read_data1;
  assign data2 = byp2 ? bus.wb_write_data : bus.id_read_data2;

  // Instruction really enters EX only without flush and without bubble.
  assign take  = bus.id_valid && !bus.flush && !hazard;

  // Flush kills the decode instruction, so IF/ID must advance, not stall.
  assign bus.stall_if_id = bus.ex_hold || (hazard && !bus.flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.ex_alu_op    <= '0;
      bus.ex_read_reg1 <= '0;
      bus.ex_read_reg2 <= '0;
      bus.ex_write_reg <= '0;
      bus.ex_data1     <= '0;
      bus.ex_data2     <= '0;
      bus.ex_imm       <= '0;
      bus.stall_count  <= '0;
      bus.flush_count  <= '0;
    end else if (!bus.ex_hold) begin
      // Control bits carry the kill/bubble; data fields are don't-care on
      // a bubble so they load unconditionally.
      bus.ex_valid     <= take;
      bus.ex_reg_write <= take && bus.id_reg_write;
      bus.ex_mem_read  <= take && bus.id_mem_read;
      bus.ex_mem_write <= take && bus.id_mem_write;
      bus.ex_alu_op    <= bus.id_alu_op;
      bus.ex_read_reg1 <= bus.id_read_reg1;
      bus.ex_read_reg2 <= bus.id_read_reg2;
      bus.ex_write_reg <= bus.id_write_reg;
      bus.ex_data1     <= data1;
      bus.ex_data2     <= data2;
      bus.ex_imm       <= bus.id_imm;
      if (bus.flush) begin
        if (bus.flush_count != CNT_MAX) bus.flush_count <= bus.flush_count + CNT_ONE;
      end else if (hazard) begin
        if (bus.stall_count != CNT_MAX) bus.stall_count <= bus.stall_count + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  bus2 ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic v; logic [4:0] r1, r2, wr; logic rw, mr, mw;
    logic [31:0] d1, d2; logic wbw; logic [4:0] wbr; logic [31:0] wbd; logic fl;
    logic [3:0] op; logic [31:0] imm;
    logic es, ev, erw, emr, emw; logic [4:0] ewr; logic [31:0] ed1, ed2;
    logic [15:0] esc, efc; logic chkd;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t row(
    logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] wr, logic rw, logic mr, logic mw,
    logic [31:0] d1, logic [31:0] d2, logic wbw, logic [4:0] wbr, logic [31:0] wbd, logic fl,
    logic es, logic ev, logic erw, logic emr, logic emw, logic [4:0] ewr,
    logic [31:0] ed1, logic [31:0] ed2, logic [15:0] esc, logic [15:0] efc, logic chkd);
    vec_t t;
    t.v = v; t.r1 = r1; t.r2 = r2; t.wr = wr; t.rw = rw; t.mr = mr; t.mw = mw;
    t.d1 = d1; t.d2 = d2; t.wbw = wbw; t.wbr = wbr; t.wbd = wbd; t.fl = fl;
    t.op = 4'h0; t.imm = 32'h0;
    t.es = es; t.ev = ev; t.erw = erw; t.emr = emr; t.emw = emw; t.ewr = ewr;
    t.ed1 = ed1; t.ed2 = ed2; t.esc = esc; t.efc = efc; t.chkd = chkd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                       input logic [31:0] d1, input logic [31:0] d2, input logic wbw,
                       input logic [4:0] wbr, input logic [31:0] wbd, input logic hold,
                       input logic fl, input logic [3:0] op, input logic [31:0] imm);
    bus.id_valid = v; bus.id_read_reg1 = r1; bus.id_read_reg2 = r2; bus.id_write_reg = wr;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_read_data1 = d1; bus.id_read_data2 = d2; bus.id_alu_op = op; bus.id_imm = imm;
    bus.wb_reg_write = wbw; bus.wb_write_reg = wbr; bus.wb_write_data = wbd;
    bus.ex_hold = hold; bus.flush = fl;
  endtask

  task automatic drive2(input logic v, input logic [4:0] r1, input logic [4:0] wr,
                        input logic mr);
    bus2.id_valid = v; bus2.id_read_reg1 = r1; bus2.id_read_reg2 = 5'd0;
    bus2.id_write_reg = wr; bus2.id_reg_write = 1'b1; bus2.id_mem_read = mr;
    bus2.id_mem_write = 1'b0; bus2.id_read_data1 = 32'h0; bus2.id_read_data2 = 32'h0;
    bus2.id_alu_op = 4'h0; bus2.id_imm = 32'h0;
    bus2.wb_reg_write = 1'b0; bus2.wb_write_reg = 5'd0; bus2.wb_write_data = 32'h0;
    bus2.ex_hold = 1'b0; bus2.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              v r1 r2 wr rw mr mw d1       d2            wbw wbr wbd           fl  es ev erw emr emw ewr ed1      ed2           esc efc chkd
    tbl[0]  = row(1, 1, 2, 3, 1, 0, 0, 32'd11,  32'd22,       0, 0, 32'h0,         0,  0, 1, 1, 0, 0, 3,  32'd11,  32'd22,       1'b0, 0, 1);
    tbl[1]  = row(1, 4, 7, 8, 1, 0, 1, 32'h44,  32'h0,        1, 7, 32'hDEADBEEF,  0,  0, 1, 1, 0, 1, 8,  32'h44,  32'hDEADBEEF, 0, 0, 1);
    tbl[2]  = row(1, 6, 0, 5, 1, 1, 0, 32'h66,  32'h0,        1, 6, 32'h1234,      0,  0, 1, 1, 1, 0, 5,  32'h1234, 32'h0,        0, 0, 1);
    tbl[3]  = row(1, 5, 9, 10, 1, 0, 0, 32'h55, 32'h99,       0, 0, 32'h0,         0,  1, 0, 0, 0, 0, 0,  32'h0,   32'h0,        1, 0, 0);
    tbl[4]  = row(1, 5, 9, 10, 1, 0, 0, 32'h55, 32'h99,       0, 0, 32'h0,         0,  0, 1, 1, 0, 0, 10, 32'h55,  32'h99,       1, 0, 1);
    tbl[5]  = row(1, 1, 2, 5, 1, 1, 0, 32'd1,   32'd2,        0, 0, 32'h0,         0,  0, 1, 1, 1, 0, 5,  32'd1,   32'd2,        1, 0, 1);
    tbl[6]  = row(1, 3, 5, 12, 1, 0, 0, 32'd3,  32'd5,        0, 0, 32'h0,         1,  0, 0, 0, 0, 0, 0,  32'h0,   32'h0,        1, 1, 0);
    tbl[7]  = row(1, 0, 0, 0, 1, 1, 0, 32'h0,   32'h0,        0, 0, 32'h0,         0,  0, 1, 1, 1, 0, 0,  32'h0,   32'h0,        1, 1, 1);
    tbl[8]  = row(1, 0, 0, 11, 1, 0, 0, 32'hA,  32'hB,        1, 0, 32'hFFFFFFFF,  0,  0, 1, 1, 0, 0, 11, 32'hA,   32'hB,        1, 1, 1);
    tbl[9]  = row(1, 1, 2, 7, 1, 1, 0, 32'd1,   32'd2,        0, 0, 32'h0,         0,  0, 1, 1, 1, 0, 7,  32'd1,   32'd2,        1, 1, 1);
    tbl[10] = row(0, 7, 7, 12, 1, 1, 1, 32'd3,  32'd4,        0, 0, 32'h0,         0,  0, 0, 0, 0, 0, 12, 32'd3,   32'd4,        1, 1, 1);
    tbl[11] = row(1, 1, 2, 3, 1, 0, 0, 32'd5,   32'd6,        0, 0, 32'h0,         1,  0, 0, 0, 0, 0, 0,  32'h0,   32'h0,        1, 2, 0);
    for (int i = 0; i < 12; i++) begin
      tbl[i].op  = 4'(i);
      tbl[i].imm = 32'(i) * 32'd16 + 32'd3;
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    #1;
    chk("reset.ex_valid", 32'(bus.ex_valid), 0);
    chk("reset.ex_data1", bus.ex_data1, 0);
    chk("reset.ex_write_reg", 32'(bus.ex_write_reg), 0);
    chk("reset.stall_count", 32'(bus.stall_count), 0);
    chk("reset.flush_count", 32'(bus.flush_count), 0);
    chk("reset.stall_if_id", 32'(bus.stall_if_id), 0);
    #11 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].wr, tbl[i].rw, tbl[i].mr, tbl[i].mw,
            tbl[i].d1, tbl[i].d2, tbl[i].wbw, tbl[i].wbr, tbl[i].wbd, 1'b0, tbl[i].fl,
            tbl[i].op, tbl[i].imm);
      #1;
      chk($sformatf("row%0d.stall_if_id", i), 32'(bus.stall_if_id), 32'(tbl[i].es));
      tick();
      chk($sformatf("row%0d.ex_valid", i), 32'(bus.ex_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d.ex_reg_write", i), 32'(bus.ex_reg_write), 32'(tbl[i].erw));
      chk($sformatf("row%0d.ex_mem_read", i), 32'(bus.ex_mem_read), 32'(tbl[i].emr));
      chk($sformatf("row%0d.ex_mem_write", i), 32'(bus.ex_mem_write), 32'(tbl[i].emw));
      chk($sformatf("row%0d.stall_count", i), 32'(bus.stall_count), 32'(tbl[i].esc));
      chk($sformatf("row%0d.flush_count", i), 32'(bus.flush_count), 32'(tbl[i].efc));
      if (tbl[i].chkd) begin
        chk($sformatf("row%0d.ex_write_reg", i), 32'(bus.ex_write_reg), 32'(tbl[i].ewr));
        chk($sformatf("row%0d.ex_data1", i), bus.ex_data1, tbl[i].ed1);
        chk($sformatf("row%0d.ex_data2", i), bus.ex_data2, tbl[i].ed2);
        chk($sformatf("row%0d.ex_read_reg1", i), 32'(bus.ex_read_reg1), 32'(tbl[i].r1));
        chk($sformatf("row%0d.ex_read_reg2", i), 32'(bus.ex_read_reg2), 32'(tbl[i].r2));
        chk($sformatf("row%0d.ex_alu_op", i), 32'(bus.ex_alu_op), 32'(tbl[i].op));
        chk($sformatf("row%0d.ex_imm", i), bus.ex_imm, tbl[i].imm);
      end
    end

    // hold over a pending load-use hazard with flush asserted
    drive(1, 1, 2, 5, 1, 1, 0, 32'h77, 32'h88, 0, 0, 0, 0, 0, 4'h3, 32'h100);
    tick();
    chk("hold.setup_valid", 32'(bus.ex_valid), 1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 5, 6, 9, 1, 0, 0, 32'hBAD, 32'hBAD, 1, 5, 32'hBAD, 1, 1, 4'h9, 32'hBAD);
      #1;
      chk($sformatf("hold%0d.stall_if_id", c), 32'(bus.stall_if_id), 1);
      tick();
      chk($sformatf("hold%0d.ex_valid", c), 32'(bus.ex_valid), 1);
      chk($sformatf("hold%0d.ex_mem_read", c), 32'(bus.ex_mem_read), 1);
      chk($sformatf("hold%0d.ex_write_reg", c), 32'(bus.ex_write_reg), 5);
      chk($sformatf("hold%0d.ex_data1", c), bus.ex_data1, 32'h77);
      chk($sformatf("hold%0d.ex_imm", c), bus.ex_imm, 32'h100);
      chk($sformatf("hold%0d.flush_count", c), 32'(bus.flush_count), 2);
      chk($sformatf("hold%0d.stall_count", c), 32'(bus.stall_count), 1);
    end
    drive(1, 5, 6, 9, 1, 0, 0, 32'h5, 32'h6, 0, 0, 0, 0, 0, 4'h1, 32'h0);
    #1;
    chk("release.stall_if_id", 32'(bus.stall_if_id), 1);
    tick();
    chk("release.ex_valid", 32'(bus.ex_valid), 0);
    chk("release.stall_count", 32'(bus.stall_count), 2);
    #1;
    chk("after_bubble.stall_if_id", 32'(bus.stall_if_id), 0);
    tick();
    chk("after_bubble.ex_write_reg", 32'(bus.ex_write_reg), 9);
    chk("after_bubble.ex_valid", 32'(bus.ex_valid), 1);

    // asynchronous reset in the middle of a stall
    drive(1, 1, 2, 5, 1, 1, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    tick();
    drive(1, 5, 0, 9, 1, 0, 0, 32'h3, 32'h4, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    #1;
    chk("pre_reset.stall_if_id", 32'(bus.stall_if_id), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.ex_valid", 32'(bus.ex_valid), 0);
    chk("async_reset.ex_mem_read", 32'(bus.ex_mem_read), 0);
    chk("async_reset.ex_write_reg", 32'(bus.ex_write_reg), 0);
    chk("async_reset.ex_data1", bus.ex_data1, 0);
    chk("async_reset.stall_count", 32'(bus.stall_count), 0);
    chk("async_reset.flush_count", 32'(bus.flush_count), 0);
    chk("async_reset.stall_if_id", 32'(bus.stall_if_id), 0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset.ex_valid", 32'(bus.ex_valid), 1);
    chk("post_reset.ex_write_reg", 32'(bus.ex_write_reg), 9);
    chk("post_reset.stall_count", 32'(bus.stall_count), 0);

    // narrow counter saturates instead of wrapping
    for (int i = 0; i < 5; i++) begin
      drive2(1, 5'd1, 5'd5, 1'b1);
      tick();
      drive2(1, 5'd5, 5'd6, 1'b0);
      #1;
      chk($sformatf("sat%0d.stall_if_id", i), 32'(bus2.stall_if_id), 1);
      tick();
      chk($sformatf("sat%0d.stall_count", i), 32'(bus2.stall_count), (i < 3) ? i + 1 : 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
